// File: rtl/nand_seq_pkg.sv
// Opcodes, FSM states, step counts and micro-op encoding for the NAND gate sequencer.
// Pure definitions: no latency and no backpressure of its own.
// Imported by nand_gate_sequencer.
package nand_seq_pkg;

    typedef enum logic [2:0] {
        OP_NOTA = 3'd0,
        OP_NOTB = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_NOR  = 3'd4,
        OP_XOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_NAND = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {SRC_A, SRC_B, SRC_R0, SRC_R1, SRC_R2} src_e;
    typedef enum logic [1:0] {DST_R0, DST_R1, DST_R2} dst_e;

    typedef struct packed {
        src_e src_x;
        src_e src_y;
        dst_e dst;
    } uop_t;

    localparam logic [2:0] STEPS_NOTA = 3'd1;
    localparam logic [2:0] STEPS_NOTB = 3'd1;
    localparam logic [2:0] STEPS_AND  = 3'd2;
    localparam logic [2:0] STEPS_OR   = 3'd3;
    localparam logic [2:0] STEPS_NOR  = 3'd4;
    localparam logic [2:0] STEPS_XOR  = 3'd5;
    localparam logic [2:0] STEPS_XNOR = 3'd6;
    localparam logic [2:0] STEPS_NAND = 3'd1;

    function automatic logic [2:0] step_count(input op_e op);
        case (op)
            OP_NOTA: step_count = STEPS_NOTA;
            OP_NOTB: step_count = STEPS_NOTB;
            OP_AND:  step_count = STEPS_AND;
            OP_OR:   step_count = STEPS_OR;
            OP_NOR:  step_count = STEPS_NOR;
            OP_XOR:  step_count = STEPS_XOR;
            OP_XNOR: step_count = STEPS_XNOR;
            default: step_count = STEPS_NAND;
        endcase
    endfunction

    function automatic uop_t mk_uop(input src_e x, input src_e y, input dst_e d);
        mk_uop = '{src_x: x, src_y: y, dst: d};
    endfunction

endpackage

// File: rtl/nand2_cell.sv
// Shared W-bit two-input NAND evaluator.
// Latency: combinational.
// Backpressure: none.
module nand2_cell #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    assign y = ~(a & b);

endmodule

// File: rtl/nand_gate_sequencer.sv
// Evaluates 8 bitwise gate functions as micro-programs on one shared NAND cell.
// Latency: N cycles from acceptance to DONE (N = 1..6 per opcode).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module nand_gate_sequencer
    import nand_seq_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_y,
    output logic [2:0]    out_op,
    output logic          busy,
    output logic [CW-1:0] op_count
);

    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic [2:0]    step_q, step_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic [W-1:0]  r0_q, r0_d, r1_q, r1_d, r2_q, r2_d;
    logic [CW-1:0] cnt_q, cnt_d;

    uop_t          uop;
    logic [W-1:0]  nand_x, nand_y_in, nand_y;
    logic [2:0]    last_step;

    // Micro-program ROM: NOR/XNOR reuse OR/XOR and fall into the final invert step.
    always_comb begin
        uop = mk_uop(SRC_A, SRC_A, DST_R0);
        case (op_q)
            OP_NOTA: uop = mk_uop(SRC_A, SRC_A, DST_R0);
            OP_NOTB: uop = mk_uop(SRC_B, SRC_B, DST_R0);
            OP_NAND: uop = mk_uop(SRC_A, SRC_B, DST_R0);
            OP_AND:  uop = (step_q == 3'd0) ? mk_uop(SRC_A, SRC_B, DST_R0)
                                            : mk_uop(SRC_R0, SRC_R0, DST_R0);
            OP_OR, OP_NOR: begin
                case (step_q)
                    3'd0:    uop = mk_uop(SRC_A,  SRC_A,  DST_R0);
                    3'd1:    uop = mk_uop(SRC_B,  SRC_B,  DST_R1);
                    3'd2:    uop = mk_uop(SRC_R0, SRC_R1, DST_R0);
                    default: uop = mk_uop(SRC_R0, SRC_R0, DST_R0);
                endcase
            end
            default: begin
                case (step_q)
                    3'd0:    uop = mk_uop(SRC_A,  SRC_A,  DST_R0);
                    3'd1:    uop = mk_uop(SRC_B,  SRC_B,  DST_R1);
                    3'd2:    uop = mk_uop(SRC_A,  SRC_R1, DST_R2);
                    3'd3:    uop = mk_uop(SRC_B,  SRC_R0, DST_R1);
                    3'd4:    uop = mk_uop(SRC_R2, SRC_R1, DST_R0);
                    default: uop = mk_uop(SRC_R0, SRC_R0, DST_R0);
                endcase
            end
        endcase
    end

    always_comb begin
        nand_x = a_q;
        case (uop.src_x)
            SRC_A:   nand_x = a_q;
            SRC_B:   nand_x = b_q;
            SRC_R0:  nand_x = r0_q;
            SRC_R1:  nand_x = r1_q;
            SRC_R2:  nand_x = r2_q;
            default: nand_x = '0;
        endcase
        nand_y_in = a_q;
        case (uop.src_y)
            SRC_A:   nand_y_in = a_q;
            SRC_B:   nand_y_in = b_q;
            SRC_R0:  nand_y_in = r0_q;
            SRC_R1:  nand_y_in = r1_q;
            SRC_R2:  nand_y_in = r2_q;
            default: nand_y_in = '0;
        endcase
    end

    nand2_cell #(.W(W)) u_nand (
        .a (nand_x),
        .b (nand_y_in),
        .y (nand_y)
    );

    assign last_step = step_count(op_q) - 3'd1;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        step_d  = step_q;
        a_d     = a_q;
        b_d     = b_q;
        r0_d    = r0_q;
        r1_d    = r1_q;
        r2_d    = r2_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d    = op_e'(in_op);
                    a_d     = in_a;
                    b_d     = in_b;
                    step_d  = 3'd0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (uop.dst)
                    DST_R0:  r0_d = nand_y;
                    DST_R1:  r1_d = nand_y;
                    DST_R2:  r2_d = nand_y;
                    default: r0_d = nand_y;
                endcase
                if (step_q == last_step) begin
                    step_d  = 3'd0;
                    state_d = ST_DONE;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOTA;
            step_q  <= 3'd0;
            a_q     <= '0;
            b_q     <= '0;
            r0_q    <= '0;
            r1_q    <= '0;
            r2_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            step_q  <= step_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r0_q    <= r0_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_EXEC) || (state_q == ST_DONE);
    assign out_y     = out_valid ? r0_q : '0;
    assign out_op    = out_valid ? op_q : 3'd0;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_nand_gate_sequencer.sv
// Scoreboard bench for nand_gate_sequencer (W=8, CW=4 so the counter wrap is reachable).
module tb_nand_gate_sequencer;

    localparam int W  = 8;
    localparam int CW = 4;

    typedef struct packed {
        logic [W-1:0] y;
        logic [2:0]   op;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_op = 3'd0;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_y;
    logic [2:0]    out_op;
    logic          busy;
    logic [CW-1:0] op_count;

    int            tests_run = 0;
    int            fails = 0;
    logic [CW-1:0] exp_cnt = '0;
    exp_t          sb_q[$];

    nand_gate_sequencer #(.W(W), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_op    (out_op),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_y(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'd0:    model_y = ~a;
            3'd1:    model_y = ~b;
            3'd2:    model_y = a & b;
            3'd3:    model_y = a | b;
            3'd4:    model_y = ~(a | b);
            3'd5:    model_y = a ^ b;
            3'd6:    model_y = ~(a ^ b);
            default: model_y = ~(a & b);
        endcase
    endfunction

    function automatic int model_steps(input logic [2:0] op);
        case (op)
            3'd2:    model_steps = 2;
            3'd3:    model_steps = 3;
            3'd4:    model_steps = 4;
            3'd5:    model_steps = 5;
            3'd6:    model_steps = 6;
            default: model_steps = 1;
        endcase
    endfunction

    // One full transaction: accept, wait for DONE, optional stall, handshake.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int stall, input bit toggle_a, input bit keep_ready);
        exp_t         e;
        exp_t         got;
        int           lat;
        logic [W-1:0] held;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        tests_run++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL accept_ready op=%0d: got %b want 1", op, in_ready);
        end
        e.y  = model_y(op, a, b);
        e.op = op;
        sb_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a     = toggle_a ? ~a : W'($urandom);
        in_b     = W'($urandom);
        in_op    = 3'($urandom);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            in_a  = toggle_a ? ~in_a : W'($urandom);
            in_b  = W'($urandom);
            in_op = 3'($urandom);
        end
        tests_run++;
        if (lat != model_steps(op)) begin
            fails++;
            $display("FAIL latency op=%0d: got %0d want %0d", op, lat, model_steps(op));
        end
        tests_run++;
        if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL result op=%0d: scoreboard empty", op);
        end else begin
            got = sb_q.pop_front();
            if (out_y !== got.y || out_op !== got.op || busy !== 1'b1) begin
                fails++;
                $display("FAIL result op=%0d: got y=%h op=%0d busy=%b want y=%h op=%0d busy=1",
                         op, out_y, out_op, busy, got.y, got.op);
            end
        end
        held = out_y;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            in_a     = W'($urandom);
            @(posedge clk); #1;
            tests_run++;
            if (out_valid !== 1'b1 || out_y !== held || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL stall cycle %0d: got vld=%b y=%h rdy=%b want vld=1 y=%h rdy=0",
                         i, out_valid, out_y, in_ready, held);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = keep_ready;
        exp_cnt   = exp_cnt + CW'(1);
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_y !== '0 || op_count !== exp_cnt) begin
            fails++;
            $display("FAIL handshake op=%0d: got vld=%b rdy=%b busy=%b y=%h cnt=%0d want 0 1 0 00 cnt=%0d",
                     op, out_valid, in_ready, busy, out_y, op_count, exp_cnt);
        end
        in_valid = 1'b0;
    endtask

    task automatic check_idle_outputs(input string name);
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_y !== '0 || out_op !== 3'd0 ||
            busy !== 1'b0 || op_count !== '0) begin
            fails++;
            $display("FAIL %s: got rdy=%b vld=%b y=%h op=%0d busy=%b cnt=%0d want 1 0 00 0 0 0",
                     name, in_ready, out_valid, out_y, out_op, busy, op_count);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_exec();
        int seen;
        in_valid = 1'b1;
        in_op    = 3'd5;
        in_a     = 8'hCA;
        in_b     = 8'h5F;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("reset_mid_exec");
        exp_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        tests_run++;
        if (seen != 0 || op_count !== '0) begin
            fails++;
            $display("FAIL reset_abort: got valid_cycles=%0d cnt=%0d want 0 0", seen, op_count);
        end
    endtask

    task automatic test_spec_vectors();
        out_ready = 1'b0;
        run_op(3'd5, 8'hCA, 8'h5F, 0, 1'b0, 1'b0);
        run_op(3'd6, 8'hCA, 8'h5F, 0, 1'b0, 1'b0);
        run_op(3'd3, 8'hA0, 8'h05, 0, 1'b0, 1'b0);
        run_op(3'd4, 8'hA0, 8'h05, 0, 1'b0, 1'b0);
    endtask

    task automatic test_all_ops();
        for (int op = 0; op < 8; op++) begin
            run_op(3'(op), W'($urandom), W'($urandom), 0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        run_op(3'd2, 8'hF0, 8'h3C, 4, 1'b0, 1'b0);
        @(posedge clk); #1;
        tests_run++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_release: got rdy=%b busy=%b want 1 0", in_ready, busy);
        end
    endtask

    task automatic test_operand_change();
        out_ready = 1'b0;
        run_op(3'd0, 8'h81, 8'h00, 0, 1'b1, 1'b0);
        run_op(3'd6, 8'h3C, 8'h96, 2, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = '0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            run_op(3'd7, 8'hFF, 8'h0F, 0, 1'b0, 1'b1);
            if (i == 14) begin
                tests_run++;
                if (op_count !== 4'd15) begin
                    fails++;
                    $display("FAIL count_max: got %0d want 15", op_count);
                end
            end
        end
        out_ready = 1'b0;
        tests_run++;
        if (op_count !== 4'd0) begin
            fails++;
            $display("FAIL count_wrap: got %0d want 0", op_count);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_exec();
        test_spec_vectors();
        test_all_ops();
        test_backpressure();
        test_operand_change();
        test_back_to_back();
        tests_run++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d leftover want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
